// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and multiplier result streams in, register-file
// write port and front-end stall out.
interface wb_arbiter_if #(
  parameter int DW = 16
);
  logic [15:0]   alu_instr;
  logic [DW-1:0] alu_result;
  logic [15:0]   mul_instr;
  logic [DW-1:0] mul_product;
  logic [1:0]    mul_status;
  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [15:0]   wb_instr;
  logic          stall;
  logic          overflow;
  logic [15:0]   collision_cnt;

  // Flow control: there is no ready on the result streams. The multiplier is
  // always accepted; while stall = 1 the producer drives alu_instr = 0 and
  // starts no new multiply, and anything pushed into a full park FIFO is dropped.
  modport master (
    output alu_instr, alu_result, mul_instr, mul_product, mul_status,
    input  rf_we, rf_waddr, rf_wdata, wb_instr, stall, overflow, collision_cnt
  );

  modport slave (
    input  alu_instr, alu_result, mul_instr, mul_product, mul_status,
    output rf_we, rf_waddr, rf_wdata, wb_instr, stall, overflow, collision_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges the single-cycle ALU and 3-stage multiplier result streams onto one
// register-file write port; ALU results that collide with the multiplier are parked.
module wb_arbiter #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 16 + DW;

  typedef logic [PW:0] cnt_t;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  cnt_t          count;

  logic          mul_v, alu_v, empty, full;
  logic          pop, push_req, push, drop;
  logic          sel_we;
  logic [15:0]   sel_instr;
  logic [DW-1:0] sel_data;

  logic          rf_we_q;
  logic [3:0]    rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  logic [15:0]   wb_instr_q;
  logic          overflow_q;
  logic [15:0]   coll_q;

  // Reserved collision lookahead; intentionally has no effect on arbitration.
  logic unused_lookahead;
  assign unused_lookahead = bus.mul_status[1];

  assign mul_v    = bus.mul_status[0];
  assign alu_v    = (bus.alu_instr != 16'h0000);
  assign empty    = (count == '0);
  assign full     = (count == cnt_t'(DEPTH));
  assign pop      = !mul_v && !empty;
  assign push_req = alu_v && (mul_v || !empty);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    sel_we    = 1'b0;
    sel_instr = 16'h0000;
    sel_data  = '0;
    if (mul_v) begin
      sel_we    = 1'b1;
      sel_instr = bus.mul_instr;
      sel_data  = bus.mul_product;
    end else if (!empty) begin
      sel_we               = 1'b1;
      {sel_instr, sel_data} = mem[rptr];
    end else if (alu_v) begin
      sel_we    = 1'b1;
      sel_instr = bus.alu_instr;
      sel_data  = bus.alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.alu_instr, bus.alu_result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 4'h0;
      rf_wdata_q <= '0;
      wb_instr_q <= 16'h0000;
      overflow_q <= 1'b0;
      coll_q     <= 16'h0000;
    end else begin
      rf_we_q    <= sel_we;
      rf_waddr_q <= sel_instr[11:8];
      rf_wdata_q <= sel_data;
      wb_instr_q <= sel_instr;
      if (drop) overflow_q <= 1'b1;
      if (mul_v && alu_v && coll_q != 16'hFFFF) coll_q <= coll_q + 16'h0001;
    end
  end

  assign bus.rf_we         = rf_we_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.wb_instr      = wb_instr_q;
  assign bus.stall         = !empty;
  assign bus.overflow      = overflow_q;
  assign bus.collision_cnt = coll_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic,
// all compared against a queue-based model of the writeback rules.
module tb_wb_arbiter;
  localparam int DW    = 16;
  localparam int DEPTH = 2;
  localparam int EW    = 16 + DW;

  logic clk;
  logic rst_n;

  wb_arbiter_if #(.DW(DW)) bus ();

  wb_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [EW-1:0] exp_q[$];
  logic          m_ovf;
  int            m_coll;
  logic          e_we;
  logic [15:0]   e_instr;
  logic [DW-1:0] e_data;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_coll  = 0;
    e_we    = 1'b0;
    e_instr = 16'h0000;
    e_data  = '0;
  endtask

  task automatic drive_idle();
    bus.alu_instr   = 16'h0000;
    bus.alu_result  = '0;
    bus.mul_instr   = 16'h0000;
    bus.mul_product = '0;
    bus.mul_status  = 2'b00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rf_we"}, 32'(bus.rf_we), 32'(e_we));
    check({tag, ".wb_instr"}, 32'(bus.wb_instr), 32'(e_instr));
    if (e_we) begin
      check({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(e_instr[11:8]));
      check({tag, ".rf_wdata"}, 32'(bus.rf_wdata), 32'(e_data));
    end
    check({tag, ".stall"}, 32'(bus.stall), 32'(exp_q.size() != 0));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, ".collision_cnt"}, 32'(bus.collision_cnt), 32'(m_coll));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rf_we"}, 32'(bus.rf_we), 32'd0);
    check({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
    check({tag, ".rf_wdata"}, 32'(bus.rf_wdata), 32'd0);
    check({tag, ".wb_instr"}, 32'(bus.wb_instr), 32'd0);
    check({tag, ".stall"}, 32'(bus.stall), 32'd0);
    check({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, ".collision_cnt"}, 32'(bus.collision_cnt), 32'd0);
  endtask

  task automatic park(input logic [15:0] ai, input logic [DW-1:0] ar);
    if (exp_q.size() < DEPTH) exp_q.push_back({ai, ar});
    else m_ovf = 1'b1;
  endtask

  // Called just after a falling edge: apply one cycle of inputs, predict, check.
  task automatic step(input string tag,
                      input logic [15:0] ai, input logic [DW-1:0] ar,
                      input logic [15:0] mi, input logic [DW-1:0] mp,
                      input logic [1:0] ms);
    logic mv, av;
    bus.alu_instr   = ai;
    bus.alu_result  = ar;
    bus.mul_instr   = mi;
    bus.mul_product = mp;
    bus.mul_status  = ms;
    mv = ms[0];
    av = (ai != 16'h0000);
    if (mv && av && m_coll < 65535) m_coll++;
    if (mv) begin
      e_we = 1'b1; e_instr = mi; e_data = mp;
      if (av) park(ai, ar);
    end else if (exp_q.size() != 0) begin
      e_we = 1'b1;
      {e_instr, e_data} = exp_q.pop_front();
      if (av) park(ai, ar);
    end else if (av) begin
      e_we = 1'b1; e_instr = ai; e_data = ar;
    end else begin
      e_we = 1'b0; e_instr = 16'h0000; e_data = '0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 16'h0, '0, 16'h0, '0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input string tag, input int cycles, input bit obey_stall);
    logic [15:0]   ai, mi;
    logic [DW-1:0] ar, mp;
    logic [1:0]    ms;
    bit            busy;
    for (int i = 0; i < cycles; i++) begin
      busy = (exp_q.size() != 0);
      ai = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
      ar = DW'($urandom);
      mi = 16'($urandom);
      mp = DW'($urandom);
      ms = 2'($urandom_range(0, 3));
      if (obey_stall && busy) begin
        ai = 16'h0000;
        if ($urandom_range(0, 3) != 0) ms[0] = 1'b0;
      end
      step(tag, ai, ar, mi, mp, ms);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    do_reset();

    // ALU only: bypass straight to writeback
    step("alu_only", 16'h1300, 16'h00AA, 16'h0, '0, 2'b00);
    idle("alu_only_idle", 1);

    // Mul only
    step("mul_only", 16'h0, '0, 16'h2700, 16'hFFFF, 2'b01);
    idle("mul_only_idle", 1);

    // Collision: mul first, parked ALU next cycle
    step("coll", 16'h1500, 16'h0055, 16'h2200, 16'h000C, 2'b01);
    idle("coll_drain", 2);

    // Drain with a trailing mul: r2, r9, r5
    step("trail_coll", 16'h1500, 16'h0055, 16'h2200, 16'h000C, 2'b01);
    step("trail_mul", 16'h0, '0, 16'h2900, 16'h0001, 2'b11);
    idle("trail_drain", 2);

    // Overflow: three back-to-back collisions ignoring stall
    step("ovf1", 16'h1100, 16'h0011, 16'h2100, 16'h0101, 2'b01);
    step("ovf2", 16'h1200, 16'h0022, 16'h2300, 16'h0303, 2'b01);
    step("ovf3", 16'h1400, 16'h0044, 16'h2400, 16'h0404, 2'b01);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    idle("ovf_drain", 4);

    // Reset mid-drain: parked result is discarded, outputs clear immediately
    step("rst_coll", 16'h1600, 16'h0066, 16'h2600, 16'h0606, 2'b01);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_alu", 16'h1A00, 16'h00A5, 16'h0, '0, 2'b00);
    idle("post_rst_idle", 2);

    // Random traffic honouring the stall contract, then unconstrained
    random_phase("rand_contract", 400, 1'b1);
    idle("rand_contract_drain", 3);
    do_reset();
    random_phase("rand_free", 400, 1'b0);
    idle("rand_free_drain", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
